// File: rtl/sram_sync_model.sv
// sram_sync_model
//   Behavioural, cycle-based model of a synchronous SRAM. It is used as the
//   memory behind an SRAM controller in simulation and also maps onto block
//   RAM. Writes commit on a sampled falling edge of SRAM_WE_B. Reads come out
//   of a READ_LATENCY-deep pipeline. Protocol violations and committed writes
//   are counted.
//
// Parameters
//   ADDR_WIDTH    word address bits (depth 2**ADDR_WIDTH)
//   DATA_WIDTH    word width, must equal 8*LANES
//   LANES         number of byte lanes
//   READ_LATENCY  0 = combinational read, 1..3 = registered pipeline depth
//
// Ports
//   BUS_CLK       single clock, all state updates on its rising edge
//   BUS_RST       synchronous active-high reset
//   SRAM_A        word address
//   SRAM_IO_IN    write data from the controller
//   SRAM_IO_OUT   read data, zero when not valid
//   SRAM_IO_OE    high while SRAM_IO_OUT carries valid read data
//   SRAM_BE_B     active-low byte-lane enables (lane i = bits [8i+7:8i])
//   SRAM_CE_B     active-low chip enable
//   SRAM_OE_B     active-low output enable
//   SRAM_WE_B     active-low write enable
//   ERR_COUNT     saturating count of cycles with a protocol violation
//   WR_COUNT      wrapping count of committed writes
module sram_sync_model #(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LANES        = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic [ADDR_WIDTH-1:0] SRAM_A,
  input  logic [DATA_WIDTH-1:0] SRAM_IO_IN,
  output logic [DATA_WIDTH-1:0] SRAM_IO_OUT,
  output logic                  SRAM_IO_OE,
  input  logic [LANES-1:0]      SRAM_BE_B,
  input  logic                  SRAM_CE_B,
  input  logic                  SRAM_OE_B,
  input  logic                  SRAM_WE_B,
  output logic [15:0]           ERR_COUNT,
  output logic [31:0]           WR_COUNT
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately never reset: unwritten words read back as X.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  we_q;     // WE_B sampled in the previous cycle
  logic                  we_arm;   // WE_B seen high before this cycle's low
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic                  wr_commit;
  logic                  rd_req;
  logic                  wr_rd_clash;
  logic                  hold_break;
  logic                  viol;

  // Lanes whose enable is inactive read back as zero.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(
    input logic [DATA_WIDTH-1:0] word,
    input logic [LANES-1:0]      be_b
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be_b[i]) res[8*i +: 8] = 8'h00;
    end
    return res;
  endfunction

  // we_q is forced high in reset. we_arm remembers whether WE_B was really
  // high in the last reset cycle. A WE_B held low across reset release
  // therefore does not look like a falling edge. A WE_B that really falls
  // in the first cycle after reset still does.
  always_comb begin
    wr_commit   = ~SRAM_CE_B & we_q & we_arm & ~SRAM_WE_B;
    rd_req      = ~SRAM_CE_B & ~SRAM_OE_B & SRAM_WE_B;
    wr_rd_clash = ~SRAM_OE_B & ~SRAM_WE_B;
    hold_break  = ~we_q & ~SRAM_WE_B &
                  ((SRAM_A != a_q) | (SRAM_IO_IN != din_q));
    viol        = ~SRAM_CE_B & (wr_rd_clash | hold_break);
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      we_q      <= 1'b1;
      we_arm    <= SRAM_WE_B;
      ERR_COUNT <= '0;
      WR_COUNT  <= '0;
    end else begin
      we_q   <= SRAM_WE_B;
      we_arm <= 1'b1;
      if (wr_commit) WR_COUNT <= WR_COUNT + 32'd1;
      if (viol && (ERR_COUNT != '1)) ERR_COUNT <= ERR_COUNT + 16'd1;
    end
  end

  // Previous-cycle address and data, used for the hold check while WE_B is low.
  always_ff @(posedge BUS_CLK) begin
    a_q   <= SRAM_A;
    din_q <= SRAM_IO_IN;
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST && wr_commit) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!SRAM_BE_B[i]) mem[SRAM_A][8*i +: 8] <= SRAM_IO_IN[8*i +: 8];
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb
    assign SRAM_IO_OE  = rd_req & ~BUS_RST;
    assign SRAM_IO_OUT = SRAM_IO_OE ? lane_mask(mem[SRAM_A], SRAM_BE_B) : '0;
  end else begin : g_pipe
    // The head of the pipeline is the request whose data is loaded into the
    // output register on this edge. The memory is read at that edge, so a
    // write committing on the same edge is not yet visible (read-before-write).
    logic                  head_v;
    logic [ADDR_WIDTH-1:0] head_a;
    logic [LANES-1:0]      head_be;
    logic                  out_oe;
    logic [DATA_WIDTH-1:0] out_q;

    if (READ_LATENCY == 1) begin : g_direct
      always_comb begin
        head_v  = rd_req;
        head_a  = SRAM_A;
        head_be = SRAM_BE_B;
      end
    end else begin : g_stages
      localparam int unsigned STAGES = READ_LATENCY - 1;

      logic [STAGES-1:0]     st_v;
      logic [ADDR_WIDTH-1:0] st_a  [STAGES];
      logic [LANES-1:0]      st_be [STAGES];

      always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
          st_v <= '0;
        end else begin
          st_v[0] <= rd_req;
          for (int unsigned i = 1; i < STAGES; i++) st_v[i] <= st_v[i-1];
        end
      end

      // Address and lane mask travel with the request; only st_v qualifies them.
      always_ff @(posedge BUS_CLK) begin
        st_a[0]  <= SRAM_A;
        st_be[0] <= SRAM_BE_B;
        for (int unsigned i = 1; i < STAGES; i++) begin
          st_a[i]  <= st_a[i-1];
          st_be[i] <= st_be[i-1];
        end
      end

      always_comb begin
        head_v  = st_v[STAGES-1];
        head_a  = st_a[STAGES-1];
        head_be = st_be[STAGES-1];
      end
    end

    always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
        out_oe <= 1'b0;
        out_q  <= '0;
      end else begin
        out_oe <= head_v;
        out_q  <= head_v ? lane_mask(mem[head_a], head_be) : '0;
      end
    end

    assign SRAM_IO_OE  = out_oe;
    assign SRAM_IO_OUT = out_q;
  end

endmodule

// File: tb/tb_sram_sync_model.sv
// tb_sram_sync_model
//   Four 16-bit instances (READ_LATENCY 0..3) share one stimulus bus and are
//   checked every cycle against a reference model. The model keeps the
//   memory as an associative array and the recent request history, and
//   derives outputs and counters from the rules of the memory. A separate
//   32-bit, 4-lane instance covers the wide-lane configuration.
module tb_sram_sync_model;

  logic        clk;
  logic        rst;
  logic [19:0] a;
  logic [15:0] din;
  logic [1:0]  be;
  logic        ce_b, oe_b, we_b;

  logic [15:0] out_l [4];
  logic        oe_l  [4];
  logic [15:0] err_l [4];
  logic [31:0] wr_l  [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    sram_sync_model #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .LANES(2), .READ_LATENCY(k)) u_dut (
      .BUS_CLK    (clk),
      .BUS_RST    (rst),
      .SRAM_A     (a),
      .SRAM_IO_IN (din),
      .SRAM_IO_OUT(out_l[k]),
      .SRAM_IO_OE (oe_l[k]),
      .SRAM_BE_B  (be),
      .SRAM_CE_B  (ce_b),
      .SRAM_OE_B  (oe_b),
      .SRAM_WE_B  (we_b),
      .ERR_COUNT  (err_l[k]),
      .WR_COUNT   (wr_l[k])
    );
  end

  logic        rst32;
  logic [9:0]  a32;
  logic [31:0] din32, out32;
  logic [3:0]  be32;
  logic        ce32, oe32_b, we32, oe32;
  logic [15:0] err32;
  logic [31:0] wr32;

  sram_sync_model #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LANES(4), .READ_LATENCY(1)) u_w32 (
    .BUS_CLK    (clk),
    .BUS_RST    (rst32),
    .SRAM_A     (a32),
    .SRAM_IO_IN (din32),
    .SRAM_IO_OUT(out32),
    .SRAM_IO_OE (oe32),
    .SRAM_BE_B  (be32),
    .SRAM_CE_B  (ce32),
    .SRAM_OE_B  (oe32_b),
    .SRAM_WE_B  (we32),
    .ERR_COUNT  (err32),
    .WR_COUNT   (wr32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] mm [bit [19:0]];
  logic        h_req [4];
  logic [19:0] h_a   [4];
  logic [1:0]  h_be  [4];
  logic        h_rst [4];
  logic        last_we, last_rst;
  logic [19:0] last_a;
  logic [15:0] last_din;
  logic [15:0] m_err;
  logic [31:0] m_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_m(input logic [19:0] addr);
    return mm.exists(addr) ? mm[addr] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] m16(input logic [15:0] w, input logic [1:0] bev);
    logic [15:0] r;
    r = w;
    if (bev[0]) r[7:0]  = 8'h00;
    if (bev[1]) r[15:8] = 8'h00;
    return r;
  endfunction

  task automatic cyc(input logic r, input logic ce, input logic oe, input logic we,
                     input logic [19:0] addr, input logic [1:0] bev, input logic [15:0] d);
    logic        req, commit, viol, v;
    logic [15:0] w;
    logic        e_oe  [4];
    logic [15:0] e_out [4];
    @(negedge clk);
    rst = r; ce_b = ce; oe_b = oe; we_b = we; a = addr; be = bev; din = d;
    #2;
    req = !r && !ce && !oe && we;
    chk("lat0_oe", 32'(oe_l[0]), 32'(req));
    chk("lat0_out", 32'(out_l[0]), 32'(req ? m16(rd_m(addr), bev) : 16'h0000));
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      h_req[i] = h_req[i-1]; h_a[i] = h_a[i-1]; h_be[i] = h_be[i-1]; h_rst[i] = h_rst[i-1];
    end
    h_req[0] = req; h_a[0] = addr; h_be[0] = bev; h_rst[0] = r;
    // Output after this edge for latency n: request from n-1 edges ago,
    // no reset since then, data as stored before this edge's write.
    for (int n = 1; n < 4; n++) begin
      v = h_req[n-1];
      for (int j = 0; j < n; j++) if (h_rst[j]) v = 1'b0;
      e_oe[n]  = v;
      e_out[n] = v ? m16(rd_m(h_a[n-1]), h_be[n-1]) : 16'h0000;
    end
    commit = !r && !ce && !we && last_we;
    viol   = !r && !ce && !we &&
             (!oe || (!last_rst && !last_we && (addr != last_a || d != last_din)));
    if (r) begin
      m_err = 16'h0; m_wr = 32'h0;
    end else begin
      if (commit) m_wr = m_wr + 1;
      if (viol && m_err != 16'hFFFF) m_err = m_err + 1;
    end
    if (commit) begin
      w = rd_m(addr);
      if (!bev[0]) w[7:0]  = d[7:0];
      if (!bev[1]) w[15:8] = d[15:8];
      mm[addr] = w;
    end
    last_we = we; last_rst = r; last_a = addr; last_din = d;
    #1;
    for (int n = 1; n < 4; n++) begin
      chk($sformatf("lat%0d_oe", n), 32'(oe_l[n]), 32'(e_oe[n]));
      chk($sformatf("lat%0d_out", n), 32'(out_l[n]), 32'(e_out[n]));
    end
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("lat%0d_err", n), 32'(err_l[n]), 32'(m_err));
      chk($sformatf("lat%0d_wr", n), wr_l[n], m_wr);
    end
  endtask

  task automatic wr16(input logic [19:0] addr, input logic [1:0] bev, input logic [15:0] d);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, addr, bev, d);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, addr, bev, d);
  endtask

  task automatic rd16(input logic [19:0] addr, input logic [1:0] bev);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, addr, bev, 16'h0000);
  endtask

  task automatic idle16();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 20'h0, 2'b11, 16'h0000);
  endtask

  task automatic cyc32(input logic r, input logic ce, input logic oe, input logic we,
                       input logic [9:0] addr, input logic [3:0] bev, input logic [31:0] d);
    @(negedge clk);
    rst32 = r; ce32 = ce; oe32_b = oe; we32 = we; a32 = addr; be32 = bev; din32 = d;
    @(posedge clk);
    #1;
  endtask

  int oe_seen;

  initial begin
    rst = 1'b1; ce_b = 1'b1; oe_b = 1'b1; we_b = 1'b1; a = '0; be = '1; din = '0;
    rst32 = 1'b1; ce32 = 1'b1; oe32_b = 1'b1; we32 = 1'b1; a32 = '0; be32 = '1; din32 = '0;
    for (int i = 0; i < 4; i++) begin
      h_req[i] = 1'b0; h_a[i] = '0; h_be[i] = '0; h_rst[i] = 1'b1;
    end
    last_we = 1'b1; last_rst = 1'b1; last_a = '0; last_din = '0;
    m_err = '0; m_wr = '0;

    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 2'b11, 16'h0000);

    // Full-word write then latency-1 read
    wr16(20'h00010, 2'b00, 16'hA55A);
    rd16(20'h00010, 2'b00);
    chk("basic_rd_data", 32'(out_l[1]), 32'h0000_A55A);
    chk("basic_rd_oe", 32'(oe_l[1]), 32'h1);
    chk("basic_wr_count", wr_l[1], 32'd1);

    for (int i = 0; i < 8; i++) wr16(20'(i), 2'b00, 16'(16'h1000 + i));

    // Partial write and masked read
    wr16(20'h00020, 2'b00, 16'h1234);
    wr16(20'h00020, 2'b10, 16'hFFFF);
    rd16(20'h00020, 2'b00);
    chk("partial_wr", 32'(out_l[1]), 32'h0000_12FF);
    rd16(20'h00020, 2'b01);
    chk("masked_rd", 32'(out_l[1]), 32'h0000_1200);

    // Back-to-back reads through the 3-deep pipeline
    repeat (3) idle16();
    oe_seen = 0;
    rd16(20'h0, 2'b00); if (oe_l[3]) oe_seen++;
    rd16(20'h1, 2'b00); if (oe_l[3]) oe_seen++;
    rd16(20'h2, 2'b00); if (oe_l[3]) oe_seen++;
    chk("lat3_first", 32'(out_l[3]), 32'h0000_1000);
    idle16(); if (oe_l[3]) oe_seen++;
    chk("lat3_second", 32'(out_l[3]), 32'h0000_1001);
    idle16(); if (oe_l[3]) oe_seen++;
    chk("lat3_third", 32'(out_l[3]), 32'h0000_1002);
    idle16(); if (oe_l[3]) oe_seen++;
    idle16(); if (oe_l[3]) oe_seen++;
    chk("lat3_oe_cycles", 32'(oe_seen), 32'd3);

    // Write/read clash then address change while WE_B is held low
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 20'h00030, 2'b00, 16'hBEEF);
    chk("clash_err", 32'(err_l[1]), 32'd1);
    chk("clash_no_oe", 32'(oe_l[1]), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 20'h00031, 2'b00, 16'hBEEF);
    chk("hold_err", 32'(err_l[1]), 32'd2);
    idle16();
    rd16(20'h00030, 2'b00);
    chk("clash_wr_data", 32'(out_l[1]), 32'h0000_BEEF);

    // Reset one cycle after a latency-2 read is issued
    rd16(20'h00010, 2'b00);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 2'b11, 16'h0000);
    chk("rst_err", 32'(err_l[2]), 32'h0);
    chk("rst_wr", wr_l[2], 32'h0);
    oe_seen = 0;
    repeat (3) begin idle16(); if (oe_l[2]) oe_seen++; end
    chk("rst_kill_lat2", 32'(oe_seen), 32'h0);
    rd16(20'h00010, 2'b00);
    chk("mem_kept", 32'(out_l[1]), 32'h0000_A55A);

    // WE_B held low across reset release
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 20'h00040, 2'b00, 16'h5555);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 20'h00040, 2'b00, 16'h5555);
    idle16();
    chk("held_low_no_wr", wr_l[1], 32'h0);

    // Randomized traffic on the pre-written window
    for (int n = 0; n < 400; n++) begin
      cyc(1'(($urandom % 50) == 0), 1'(($urandom % 6) == 0), 1'($urandom % 2), 1'($urandom % 2),
          20'($urandom_range(0, 7)), 2'($urandom % 4), 16'($urandom));
    end
    idle16();

    // Wide-lane instance: lane-3-only write over a zero word
    repeat (2) cyc32(1'b1, 1'b1, 1'b1, 1'b1, 10'h0, 4'hF, 32'h0);
    cyc32(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 4'b0000, 32'h0000_0000);
    cyc32(1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF, 4'b1111, 32'h0000_0000);
    cyc32(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF, 4'b0111, 32'hEE12_3456);
    cyc32(1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF, 4'b1111, 32'h0000_0000);
    cyc32(1'b0, 1'b0, 1'b0, 1'b1, 10'h3FF, 4'b0000, 32'h0000_0000);
    chk("w32_data", out32, 32'hEE00_0000);
    chk("w32_oe", 32'(oe32), 32'h1);
    chk("w32_wr", wr32, 32'd2);
    chk("w32_err", 32'(err32), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
